// File: rtl/sequenced_decoder.sv
// One-hot address decoder with a registered address and an optional scan mode.
// Scan mode is compiled only when SEQUENCED_DECODER_SCAN_EN is defined.
// Ports: clk, reset (sync, active-high), enable, mode (0 direct / 1 scan),
//   addr_valid, addr -> out (one-hot), cur_addr, wrap (rollover pulse), busy.
module sequenced_decoder #(
  parameter  int ADDR_WIDTH = 2,
  localparam int OUT_WIDTH  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  addr_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [OUT_WIDTH-1:0]  out,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  wrap,
  output logic                  busy
);

`ifdef SEQUENCED_DECODER_SCAN_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [OUT_WIDTH-1:0]  out_q, out_d;
  logic                  wrap_q, wrap_d;
  logic                  scan_req;
  logic                  scan_step;

`ifdef SEQUENCED_DECODER_SCAN_EN
  assign scan_req  = mode;
  // Advance only once already scanning; entry from another state holds.
  assign scan_step = mode && (state_q == SCAN);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign scan_req    = 1'b0;
  assign scan_step   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      out_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
    end
  end

  // Next state
  always_comb begin
    state_d = IDLE;
    if (enable) begin
`ifdef SEQUENCED_DECODER_SCAN_EN
      state_d = scan_req ? SCAN : DIRECT;
`else
      state_d = DIRECT;
`endif
    end
  end

  // Outputs: a loaded address always wins over a scan step.
  always_comb begin
    cur_addr_d = cur_addr_q;
    out_d      = '0;
    wrap_d     = 1'b0;
    if (enable) begin
      if (addr_valid) begin
        cur_addr_d = addr;
      end else if (scan_step) begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
        wrap_d     = (cur_addr_q == '1);
      end
      out_d = OUT_WIDTH'(1) << cur_addr_d;
    end
  end

  assign out      = out_q;
  assign cur_addr = cur_addr_q;
  assign wrap     = wrap_q;
  assign busy     = (state_q != IDLE);

endmodule
